// File: rtl/jamming_waveform_gen.sv
// Programmable jamming waveform source for the DAC sample bus: ramp-up, ramp-down,
// triangle and square sweeps, with new settings taking effect only on a sweep boundary.
module jamming_waveform_gen #(
  parameter int DW     = 14,
  parameter int STEP_W = 8,
  parameter int DIV_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [1:0]        cfg_mode,
  input  logic [DW-1:0]     cfg_lo,
  input  logic [DW-1:0]     cfg_hi,
  input  logic [STEP_W-1:0] cfg_step,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic [DW-1:0]     dac_data,
  output logic              sample_stb,
  output logic              sweep_start,
  output logic              toggle
);

  typedef enum logic [1:0] {
    MODE_UP   = 2'd0,
    MODE_DOWN = 2'd1,
    MODE_TRI  = 2'd2,
    MODE_SQR  = 2'd3
  } mode_e;

  localparam logic [DW-1:0] LO_RST = {1'b1, {(DW-1){1'b0}}};
  localparam logic [DW-1:0] HI_RST = {DW{1'b1}};

  // Active set
  mode_e             mode_q, mode_d;
  logic [DW-1:0]     lo_q, lo_d;
  logic [DW-1:0]     hi_q, hi_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [DIV_W-1:0]  div_q, div_d;

  // Pending bundle
  logic              pend_vld_q, pend_vld_d;
  mode_e             pend_mode_q, pend_mode_d;
  logic [DW-1:0]     pend_lo_q, pend_lo_d;
  logic [DW-1:0]     pend_hi_q, pend_hi_d;
  logic [STEP_W-1:0] pend_step_q, pend_step_d;
  logic [DIV_W-1:0]  pend_div_q, pend_div_d;

  // Waveform state
  logic [DIV_W-1:0]  pre_cnt_q, pre_cnt_d;
  logic [DW-1:0]     dac_q, dac_d;
  logic [DW-1:0]     ramp_q, ramp_d;
  logic              dir_down_q, dir_down_d;
  logic              stb_q, stb_d;
  logic              sweep_q, sweep_d;
  logic              toggle_q, toggle_d;

  // Next-sample datapath
  logic [DW:0]   s_ext, v_ext, r_ext, lo_ext, hi_ext;
  logic [DW:0]   v_up, r_up, lo_s, mid;
  logic [DW-1:0] nv, nr;
  logic          ndir, bnd;

  logic tick, accept, apply;

  always_comb begin
    s_ext  = (step_q == '0) ? (DW+1)'(1) : (DW+1)'(step_q);
    v_ext  = {1'b0, dac_q};
    r_ext  = {1'b0, ramp_q};
    lo_ext = {1'b0, lo_q};
    hi_ext = {1'b0, hi_q};
    v_up   = v_ext + s_ext;
    r_up   = r_ext + s_ext;
    lo_s   = lo_ext + s_ext;
    mid    = (lo_ext + hi_ext + (DW+1)'(1)) >> 1;

    nv   = dac_q;
    nr   = ramp_q;
    ndir = dir_down_q;
    bnd  = 1'b0;
    case (mode_q)
      MODE_UP: begin
        if (v_up > hi_ext) begin
          nv  = lo_q;
          bnd = 1'b1;
        end else begin
          nv = v_up[DW-1:0];
        end
      end
      MODE_DOWN: begin
        if (v_ext < lo_s) begin
          nv  = hi_q;
          bnd = 1'b1;
        end else begin
          nv = dac_q - s_ext[DW-1:0];
        end
      end
      MODE_TRI: begin
        if (!dir_down_q) begin
          if (v_up >= hi_ext) begin
            nv   = hi_q;
            ndir = 1'b1;
          end else begin
            nv = v_up[DW-1:0];
          end
        end else if (v_ext <= lo_s) begin
          nv   = lo_q;
          ndir = 1'b0;
          bnd  = 1'b1;
        end else begin
          nv = dac_q - s_ext[DW-1:0];
        end
      end
      MODE_SQR: begin
        // The hidden ramp sweeps like mode 0; the output snaps to lo/hi around mid.
        if (r_up > hi_ext) begin
          nr  = lo_q;
          bnd = 1'b1;
        end else begin
          nr = r_up[DW-1:0];
        end
        nv = ({1'b0, nr} < mid) ? lo_q : hi_q;
      end
      default: begin
      end
    endcase
  end

  // cfg handshake: a bundle transfers on any edge where cfg_valid && cfg_ready;
  // cfg_ready stays low from the transfer until the cycle after the bundle is applied.
  assign tick   = en && (pre_cnt_q == div_q);
  assign accept = cfg_valid && !pend_vld_q;
  assign apply  = pend_vld_q && (!en || (tick && bnd));

  always_comb begin
    mode_d      = mode_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    step_d      = step_q;
    div_d       = div_q;
    pend_vld_d  = pend_vld_q;
    pend_mode_d = pend_mode_q;
    pend_lo_d   = pend_lo_q;
    pend_hi_d   = pend_hi_q;
    pend_step_d = pend_step_q;
    pend_div_d  = pend_div_q;
    dac_d       = dac_q;
    ramp_d      = ramp_q;
    dir_down_d  = dir_down_q;
    toggle_d    = toggle_q;
    stb_d       = 1'b0;
    sweep_d     = 1'b0;

    if (!en || tick) begin
      pre_cnt_d = '0;
    end else begin
      pre_cnt_d = pre_cnt_q + DIV_W'(1);
    end

    if (accept) begin
      pend_vld_d  = 1'b1;
      pend_mode_d = mode_e'(cfg_mode);
      pend_lo_d   = cfg_lo;
      pend_hi_d   = (cfg_lo > cfg_hi) ? cfg_lo : cfg_hi;
      pend_step_d = cfg_step;
      pend_div_d  = cfg_div;
    end

    if (apply) begin
      mode_d     = pend_mode_q;
      lo_d       = pend_lo_q;
      hi_d       = pend_hi_q;
      step_d     = pend_step_q;
      div_d      = pend_div_q;
      pend_vld_d = 1'b0;
      pre_cnt_d  = '0;
      dac_d      = (pend_mode_q == MODE_DOWN) ? pend_hi_q : pend_lo_q;
      ramp_d     = pend_lo_q;
      dir_down_d = 1'b0;
      if (en) begin
        stb_d    = 1'b1;
        sweep_d  = 1'b1;
        toggle_d = ~toggle_q;
      end
    end else if (tick) begin
      dac_d      = nv;
      ramp_d     = nr;
      dir_down_d = ndir;
      toggle_d   = ~toggle_q;
      stb_d      = 1'b1;
      sweep_d    = bnd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= MODE_UP;
      lo_q        <= LO_RST;
      hi_q        <= HI_RST;
      step_q      <= STEP_W'(1);
      div_q       <= '0;
      pend_vld_q  <= 1'b0;
      pend_mode_q <= MODE_UP;
      pend_lo_q   <= '0;
      pend_hi_q   <= '0;
      pend_step_q <= '0;
      pend_div_q  <= '0;
      pre_cnt_q   <= '0;
      dac_q       <= LO_RST;
      ramp_q      <= LO_RST;
      dir_down_q  <= 1'b0;
      stb_q       <= 1'b0;
      sweep_q     <= 1'b0;
      toggle_q    <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      step_q      <= step_d;
      div_q       <= div_d;
      pend_vld_q  <= pend_vld_d;
      pend_mode_q <= pend_mode_d;
      pend_lo_q   <= pend_lo_d;
      pend_hi_q   <= pend_hi_d;
      pend_step_q <= pend_step_d;
      pend_div_q  <= pend_div_d;
      pre_cnt_q   <= pre_cnt_d;
      dac_q       <= dac_d;
      ramp_q      <= ramp_d;
      dir_down_q  <= dir_down_d;
      stb_q       <= stb_d;
      sweep_q     <= sweep_d;
      toggle_q    <= toggle_d;
    end
  end

  assign cfg_ready   = ~pend_vld_q;
  assign dac_data    = dac_q;
  assign sample_stb  = stb_q;
  assign sweep_start = sweep_q;
  assign toggle      = toggle_q;

endmodule

// File: tb/tb_jamming_waveform_gen.sv
// Randomised bench for jamming_waveform_gen: a period-list reference model predicts
// every strobed sample (cycle, sweep flag, value); a negedge monitor pops and compares.
module tb_jamming_waveform_gen;
  localparam int DW     = 14;
  localparam int STEP_W = 8;
  localparam int DIV_W  = 8;
  localparam int W      = 32 + 1 + DW;

  logic              clk, rst_n, en, cfg_valid, cfg_ready;
  logic [1:0]        cfg_mode;
  logic [DW-1:0]     cfg_lo, cfg_hi;
  logic [STEP_W-1:0] cfg_step;
  logic [DIV_W-1:0]  cfg_div;
  logic [DW-1:0]     dac_data;
  logic              sample_stb, sweep_start, toggle;

  jamming_waveform_gen #(.DW(DW), .STEP_W(STEP_W), .DIV_W(DIV_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_mode(cfg_mode), .cfg_lo(cfg_lo), .cfg_hi(cfg_hi), .cfg_step(cfg_step),
    .cfg_div(cfg_div), .dac_data(dac_data), .sample_stb(sample_stb),
    .sweep_start(sweep_start), .toggle(toggle)
  );

  typedef struct {
    int mode;
    int lo;
    int hi;
    int step;
    int div;
  } cfg_t;

  logic [W-1:0] exp_q[$];
  int n_vec, n_err, cyc;
  bit tog_exp;

  // Reference model: one full period of output samples following the start point.
  int m_val[$];
  bit m_bnd[$];
  int m_idx, m_div, m_start;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  function automatic cfg_t mk(input int mode, input int lo, input int hi, input int step, input int div);
    cfg_t c;
    c.mode = mode; c.lo = lo; c.hi = hi; c.step = step; c.div = div;
    return c;
  endfunction

  function automatic void mpush(input int v, input bit b);
    m_val.push_back(v);
    m_bnd.push_back(b);
  endfunction

  function automatic void load_model(input cfg_t c);
    int lo, hi, s, mid;
    lo = c.lo;
    hi = (c.hi < c.lo) ? c.lo : c.hi;
    s  = (c.step == 0) ? 1 : c.step;
    m_val.delete();
    m_bnd.delete();
    m_idx = 0;
    m_div = c.div;
    case (c.mode)
      0: begin
        for (int x = lo + s; x <= hi; x += s) mpush(x, 1'b0);
        mpush(lo, 1'b1);
      end
      1: begin
        for (int x = hi - s; x >= lo; x -= s) mpush(x, 1'b0);
        mpush(hi, 1'b1);
      end
      2: begin
        for (int x = lo + s; x < hi; x += s) mpush(x, 1'b0);
        mpush(hi, 1'b0);
        for (int x = hi - s; x > lo; x -= s) mpush(x, 1'b0);
        mpush(lo, 1'b1);
      end
      default: begin
        mid = (lo + hi + 1) / 2;
        for (int x = lo + s; x <= hi; x += s) mpush((x < mid) ? lo : hi, 1'b0);
        mpush((lo < mid) ? lo : hi, 1'b1);
      end
    endcase
    m_start = (c.mode == 1) ? hi : lo;
  endfunction

  function automatic void exp_push(input int e, input bit b, input int v);
    logic [W-1:0] item;
    item = {e, b, v[DW-1:0]};
    exp_q.push_back(item);
  endfunction

  function automatic cfg_t rand_cfg();
    cfg_t c;
    c.mode = $urandom_range(0, 3);
    c.lo   = $urandom_range(0, 16383);
    if ($urandom_range(0, 5) == 0) c.hi = c.lo - $urandom_range(0, 20);
    else c.hi = c.lo + $urandom_range(0, 80);
    if (c.hi < 0) c.hi = 0;
    if (c.hi > 16383) c.hi = 16383;
    c.step = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 12);
    c.div  = $urandom_range(0, 3);
    return c;
  endfunction

  // driver tasks (called just after a rising edge)
  task automatic drive_cfg(input cfg_t c);
    cfg_mode = 2'(c.mode);
    cfg_lo   = DW'(c.lo);
    cfg_hi   = DW'(c.hi);
    cfg_step = STEP_W'(c.step);
    cfg_div  = DIV_W'(c.div);
  endtask

  task automatic cfg_off(input cfg_t c);
    chk("ready_idle", cfg_ready, 1);
    cfg_valid = 1'b1;
    drive_cfg(c);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    chk("ready_after_accept", cfg_ready, 0);
    @(posedge clk); #1;
    load_model(c);
    chk("off_apply_dac", dac_data, m_start);
    chk("off_apply_ready", cfg_ready, 1);
    chk("off_apply_no_stb", sample_stb, 0);
  endtask

  task automatic run(input int n, input bit reconf, input int acc_off, input cfg_t nc, input bit keep_en);
    int c0, e, e_acc, e_app, tot;
    bit pend;
    c0 = cyc; e = c0; e_acc = c0 + acc_off; e_app = -1; pend = reconf;
    for (int j = 1; j <= n; j++) begin
      e = e + m_div + 1;
      if (pend && e > e_acc && m_bnd[m_idx]) begin
        load_model(nc);
        exp_push(e, 1'b1, m_start);
        pend  = 1'b0;
        e_app = e;
      end else begin
        exp_push(e, m_bnd[m_idx], m_val[m_idx]);
        m_idx = (m_idx + 1) % m_val.size();
      end
    end
    tot = e - c0;
    en = 1'b1;
    if (reconf && acc_off == 1) begin
      cfg_valid = 1'b1;
      drive_cfg(nc);
    end
    for (int k = 1; k <= tot; k++) begin
      @(posedge clk); #1;
      if (reconf && cyc == e_acc) begin
        cfg_valid = 1'b0;
        chk("ready_drop", cfg_ready, 0);
      end
      if (reconf && cyc + 1 == e_acc) begin
        cfg_valid = 1'b1;
        drive_cfg(nc);
      end
      if (e_app >= 0 && cyc == e_app) chk("ready_rise", cfg_ready, 1);
      if (e_app >= 0 && cyc == e_app - 1 && cyc > e_acc) chk("ready_held", cfg_ready, 0);
    end
    if (!keep_en) begin
      en = 1'b0;
      if (pend) begin
        @(posedge clk); #1;
        load_model(nc);
        chk("late_apply_dac", dac_data, m_start);
        chk("late_apply_ready", cfg_ready, 1);
      end
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] e, got;
    if (!rst_n) begin
      tog_exp = 1'b0;
    end else if (sample_stb) begin
      tog_exp = ~tog_exp;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_stb: got strobe at cyc=%0d dac=%0d, expected none", cyc, dac_data);
      end else begin
        e   = exp_q.pop_front();
        got = {cyc, sweep_start, dac_data};
        if (got !== e) begin
          n_err++;
          $display("FAIL sample: got cyc=%0d sweep=%0b dac=%0d, expected cyc=%0d sweep=%0b dac=%0d",
                   cyc, sweep_start, dac_data, e[W-1:DW+1], e[DW], e[DW-1:0]);
        end
      end
      chk("toggle_on_stb", toggle, tog_exp);
    end else begin
      chk("sweep_without_stb", sweep_start, 0);
      chk("toggle_hold", toggle, tog_exp);
    end
  end

  // stimulus
  initial begin
    cfg_t none, c, nc;
    int n;
    none = mk(0, 0, 0, 0, 0);
    rst_n = 1'b0; en = 1'b0; cfg_valid = 1'b0;
    drive_cfg(none);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dac", dac_data, 8192);
    chk("rst_stb", sample_stb, 0);
    chk("rst_sweep", sweep_start, 0);
    chk("rst_toggle", toggle, 0);
    chk("rst_ready", cfg_ready, 1);
    rst_n = 1'b1;

    // legacy upper-half sawtooth over a full wrap
    load_model(mk(0, 8192, 16383, 1, 0));
    run(8200, 1'b0, 0, none, 1'b0);

    cfg_off(mk(2, 100, 110, 4, 0));     run(20, 1'b0, 0, none, 1'b0);
    cfg_off(mk(0, 0, 3, 1, 2));         run(10, 1'b0, 0, none, 1'b0);
    cfg_off(mk(0, 0, 7, 1, 0));         run(14, 1'b1, 3, mk(1, 20, 30, 5, 0), 1'b0);
    cfg_off(mk(3, 0, 15, 0, 0));        run(40, 1'b0, 0, none, 1'b0);
    cfg_off(mk(0, 50, 40, 7, 1));       run(6, 1'b0, 0, none, 1'b0);
    cfg_off(mk(2, 9, 9, 3, 0));         run(6, 1'b0, 0, none, 1'b0);
    cfg_off(mk(1, 9, 9, 2, 0));         run(4, 1'b0, 0, none, 1'b0);
    cfg_off(mk(0, 16000, 16383, 255, 0)); run(8, 1'b0, 0, none, 1'b0);
    cfg_off(mk(2, 16000, 16383, 255, 1)); run(10, 1'b0, 0, none, 1'b0);
    cfg_off(mk(1, 0, 1000, 200, 0));    run(12, 1'b0, 0, none, 1'b0);

    for (int it = 0; it < 16; it++) begin
      c = rand_cfg();
      cfg_off(c);
      n = $urandom_range(5, 40);
      if (it % 2 == 1) begin
        nc = rand_cfg();
        run(n, 1'b1, $urandom_range(1, n * (m_div + 1)), nc, 1'b0);
      end else begin
        run(n, 1'b0, 0, none, 1'b0);
      end
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
    end

    // asynchronous reset mid-sweep with a bundle pending
    cfg_off(mk(1, 0, 5000, 1, 0));
    run(30, 1'b1, 10, mk(2, 3, 90, 6, 1), 1'b1);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("arst_dac", dac_data, 8192);
    chk("arst_stb", sample_stb, 0);
    chk("arst_sweep", sweep_start, 0);
    chk("arst_toggle", toggle, 0);
    chk("arst_ready", cfg_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    load_model(mk(0, 8192, 16383, 1, 0));
    run(8200, 1'b0, 0, none, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/jamming_waveform_gen.md
# jamming_waveform_gen

Parametrised jamming waveform source driving the DAC sample bus. It generalises the fixed 14-bit upper-half sawtooth into programmable ramp-up, ramp-down, triangle and square modes. Each mode has a configurable range, step and sample-rate divider. Configuration enters through a valid/ready handshake and takes effect only on a sweep boundary, so the DAC never sees a torn waveform.

## Interface
- `DW`, 14, DAC sample width
- `STEP_W`, 8, step-size width
- `DIV_W`, 8, sample-rate divider width
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous active-low reset
- `en`  in  1  run enable; low freezes the waveform
- `cfg_valid`  in  1  configuration bundle valid
- `cfg_ready`  out  1  block can accept a bundle
- `cfg_mode`  in  2  0 ramp-up, 1 ramp-down, 2 triangle, 3 square
- `cfg_lo`  in  DW  lower bound
- `cfg_hi`  in  DW  upper bound
- `cfg_step`  in  STEP_W  increment per sample (0 treated as 1)
- `cfg_div`  in  DIV_W  each sample is held `cfg_div`+1 cycles
- `dac_data`  out  DW  registered DAC sample
- `sample_stb`  out  1  high for the first cycle a new `dac_data` is presented
- `sweep_start`  out  1  high with the sample that starts a new period
- `toggle`  out  1  inverts on every sample update

## Operation
- **Active set:** mode, lo, hi, step, div. It is loaded from the bundle on apply.
  - Reset values: mode 0, lo 2^(DW-1), hi 2^DW-1, step 1, div 0. This default reproduces the legacy upper-half sawtooth.
- **lo > hi:** hi is replaced by lo at apply, giving a constant output.
- **Handshake:**
  - Accept on `cfg_valid && cfg_ready`. The bundle goes to a pending register and `cfg_ready` drops the next cycle.
  - With `en`=0, pending is applied on the next edge.
  - With `en`=1, pending is applied at the next sweep boundary tick, after the accept cycle. An accept coinciding with a boundary waits for the following boundary.
  - `cfg_ready` rises in the cycle after apply.
- **Apply reinitialises the waveform:**
  - `dac_data` goes to the mode start point: lo for modes 0, 2 and 3; hi for mode 1.
  - Triangle direction resets to up.
  - The internal ramp resets to lo.
  - The prescaler resets to 0.
- **Prescaler:** counts 0..div while `en`=1. tick = (`pre_cnt`==div) && `en`. On a tick the counter returns to 0.
- **Arithmetic:** all bound tests are in DW+1 bits and never overflow. Let s = max(step, 1).
- **Per-mode behaviour on each tick:**
  - **Mode 0:** if v+s > hi then v=lo and boundary, else v=v+s.
  - **Mode 1:** if v < lo+s then v=hi and boundary, else v=v-s.
  - **Mode 2, direction up:** if v+s ≥ hi then v=hi and direction becomes down, else v+s.
  - **Mode 2, direction down:** if v ≤ lo+s then v=lo, direction becomes up, and boundary; else v-s.
  - **Mode 3:**
    - The internal ramp r follows the mode-0 rule, with its boundary.
    - mid = (lo+hi+1)>>1.
    - `dac_data` = lo when the new r < mid, otherwise hi.
- **Constant range (lo==hi):**
  - Mode 0: every tick is a boundary.
  - Mode 1: every tick is a boundary.
  - Mode 3: every tick is a boundary.
  - Mode 2: a boundary occurs every second tick.
- **`en` low:** prescaler holds 0 and `dac_data` holds. No strobes, no toggles. Operation resumes on the next cycle with a full div+1 wait.

## Timing
- **Reset (async):**
  - `dac_data` = 2^(DW-1).
  - `sample_stb`, `sweep_start` and `toggle` = 0.
  - `cfg_ready` = 1, pending cleared, active set at its reset values.
  - Reset asserted mid-sweep takes effect immediately and discards any pending bundle.
- **Tick edge:** the edge at which tick is true updates `dac_data` and inverts `toggle`.
  - In the same edge `sample_stb` is registered to 1, and `sweep_start` to 1 if a boundary occurred.
  - Both strobes are single-cycle unless the next cycle is also a tick; with div=0 `sample_stb` stays high continuously.
- **Apply edge:** this is the boundary tick when running. `sweep_start`=1 and `sample_stb`=1 with the new start value. When disabled, apply produces no strobes.
- **Latency:**
  - First sample after reset with `en`=1 arrives div+1 cycles later.
  - A bundle accepted while disabled is visible on `dac_data` 1 cycle after the accept.

## Test plan
- **Default sawtooth:** reset, `en`=1, no config.
  - `dac_data` reads 8192 then 8193, 8194 … 16383, 8192, updating every cycle.
  - `sweep_start` pulses with the 8192 after 16383.
  - `toggle` inverts every cycle.
- **Triangle:** mode 2, lo=100, hi=110, step=4, div=0.
  - Sequence 100, 104, 108, 110, 106, 102, 100, 104 …
  - `sweep_start` is asserted only with each 100 produced by the down turn.
- **Divider:** div=2, mode 0, lo=0, hi=3, step=1.
  - `sample_stb` is asserted every 3rd cycle; values 1, 2, 3, 0, 1 …
  - `toggle` changes only on strobes.
- **Running reconfig:** while in mode 0, lo=0, hi=7, accept mode 1, lo=20, hi=30, step=5 mid-sweep.
  - `cfg_ready`=0 until the old 7→0 boundary.
  - At that boundary `dac_data`=30 with `sweep_start`, then 25, 20, 30.
  - `cfg_ready` returns 1 one cycle after apply.
- **Square and edge cases:**
  - Mode 3, lo=0, hi=15, step=0: 7 samples of 0, 8 of 15, then 8 of 0, 8 of 15 repeating (step 0 acts as 1).
  - lo=50, hi=40 in mode 0: constant 50 with `sweep_start` every tick.
- **Async reset:** assert `rst_n` low mid-sweep with a bundle pending.
  - Outputs go to reset values without waiting for a clock edge.
  - After release, the default sawtooth resumes from 8192.
